// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package cpu_mem_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DATA
  } mem_owner_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WAIT
  } arb_state_e;

endpackage

// File: rtl/mem_arb_select.sv
// Grant decision for the shared memory port: data first, fetch otherwise.
// Define MEM_ARB_ANTISTARVE_EN to force a fetch grant after STARVE_LIMIT data wins.
module mem_arb_select
  import cpu_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
`ifdef MEM_ARB_ANTISTARVE_EN
  input  logic clk_i,
`endif
  input  logic rst_i,
  input  logic idle_i,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic if_gnt_o,
  output logic d_gnt_o
);

  logic force_if;

`ifdef MEM_ARB_ANTISTARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;

  assign force_if = (starve_q >= SW'(STARVE_LIMIT));

  // Counts data wins taken while fetch was waiting; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || if_gnt_o) begin
      starve_d = '0;
    end else if (d_gnt_o && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    if_gnt_o = 1'b0;
    d_gnt_o  = 1'b0;
    if (!rst_i && idle_i) begin
      if (if_req_i && (force_if || !d_req_i)) begin
        if_gnt_o = 1'b1;
      end else if (d_req_i) begin
        d_gnt_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch reads and EX-stage loads/stores.
// Optional fetch anti-starvation is enabled by defining MEM_ARB_ANTISTARVE_EN.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              stall_fetch,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // state   | meaning
  // ST_IDLE | arbitrate; previous access completion pulse is visible here
  // ST_CMD  | single memory command cycle from the latched request
  // ST_WAIT | latency countdown; read data captured at terminal count

  localparam int CNT_W = $clog2(MEM_LAT) + 1;

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be >= 1");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_LIMIT must be >= 1");
  end

  arb_state_e        state_q, state_d;
  mem_owner_e        owner_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              if_rvalid_q, d_done_q;
  logic              last_wait;

  mem_arb_select #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_select (
`ifdef MEM_ARB_ANTISTARVE_EN
    .clk_i    (clk),
`endif
    .rst_i    (rst),
    .idle_i   (state_q == ST_IDLE),
    .if_req_i (if_req),
    .d_req_i  (d_req),
    .if_gnt_o (if_gnt),
    .d_gnt_o  (d_gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (if_gnt || d_gnt) state_d = ST_CMD;
      ST_CMD:  state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en = 1'b0;
    mem_we = 1'b0;
    busy   = 1'b1;
    unique case (state_q)
      ST_IDLE: busy = 1'b0;
      ST_CMD: begin
        mem_en = 1'b1;
        mem_we = we_q;
      end
      default: ;
    endcase
  end

  assign last_wait = (state_q == ST_WAIT) && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_CMD) begin
      cnt_d = CNT_W'(MEM_LAT - 1);
    end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Command registers double as the held memory address/data outside CMD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      owner_q <= OWN_NONE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (d_gnt) begin
        owner_q <= OWN_DATA;
        addr_q  <= d_addr;
        we_q    <= d_we;
        wdata_q <= d_wdata;
      end else if (if_gnt) begin
        owner_q <= OWN_IF;
        addr_q  <= if_addr;
        we_q    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid_q <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= last_wait && (owner_q == OWN_IF);
      d_done_q    <= last_wait && (owner_q == OWN_DATA);
      if (last_wait && (owner_q == OWN_IF)) begin
        if_rdata_q <= mem_rdata;
      end
      // Stores complete without disturbing the last load result.
      if (last_wait && (owner_q == OWN_DATA) && !we_q) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign if_rvalid   = if_rvalid_q;
  assign d_done      = d_done_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign stall_fetch = if_req && !if_gnt && !rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one MEM_LAT=1 instance and one MEM_LAT=3 instance.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A, MEM_LAT = 1
  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [9:0]  if_addr = '0, d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        if_gnt, if_rvalid, stall_fetch, d_gnt, d_done, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;

  // Instance B, MEM_LAT = 3
  logic        b_if_req = 0, b_d_req = 0, b_d_we = 0;
  logic [9:0]  b_if_addr = '0, b_d_addr = '0;
  logic [31:0] b_d_wdata = '0;
  logic        b_if_gnt, b_if_rvalid, b_stall_fetch, b_d_gnt, b_d_done, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
  logic [9:0]  b_mem_addr;

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .stall_fetch(stall_fetch),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_done(d_done), .d_rdata(d_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .rst(rst), .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata), .stall_fetch(b_stall_fetch),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_gnt(b_d_gnt),
    .d_done(b_d_done), .d_rdata(b_d_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy));

  function automatic logic [31:0] init_word(input logic [9:0] a);
    if (a == 10'h005) return 32'hDEADBEEF;
    if (a == 10'h3FF) return 32'hCAFEF00D;
    return {12'hC0D, 10'h000, a};
  endfunction

  // Memory A: registered read, one cycle latency; poison value when not reading.
  logic [31:0] mem_a [1024];
  bit   [1023:0] wr_a;
  logic [31:0] pipe_a;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem_a[mem_addr] <= mem_wdata;
      wr_a[mem_addr]  <= 1'b1;
    end
    pipe_a <= (mem_en && !mem_we) ? (wr_a[mem_addr] ? mem_a[mem_addr] : init_word(mem_addr))
                                  : 32'hBAD0_0001;
  end
  assign mem_rdata = pipe_a;

  // Memory B: read-only, three cycle latency.
  logic [31:0] pipe_b [3];
  always @(posedge clk) begin
    pipe_b[0] <= (b_mem_en && !b_mem_we) ? init_word(b_mem_addr) : 32'hBAD0_0002;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign b_mem_rdata = pipe_b[2];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; if_addr = 10'h005;
    @(negedge clk);
    n_vec++; if (if_gnt !== 1'b0) begin n_err++; $display("FAIL rst_if_gnt: got %b expected 0", if_gnt); end
    n_vec++; if (stall_fetch !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b expected 0", stall_fetch); end
    n_vec++; if ({busy, mem_en, mem_we, if_rvalid, d_done} !== 5'b0) begin n_err++; $display("FAIL rst_ctrl: got %b expected 00000", {busy, mem_en, mem_we, if_rvalid, d_done}); end
    n_vec++; if ({if_rdata, d_rdata, mem_wdata} !== 96'h0 || mem_addr !== 10'h0) begin n_err++; $display("FAIL rst_data: got %h %h %h %h expected zeros", if_rdata, d_rdata, mem_wdata, mem_addr); end
    next_cycle(); rst = 1'b0;
    @(negedge clk);
    n_vec++; if (if_gnt !== 1'b1) begin n_err++; $display("FAIL t1_if_gnt: got %b expected 1", if_gnt); end
    n_vec++; if (stall_fetch !== 1'b0) begin n_err++; $display("FAIL t1_stall: got %b expected 0", stall_fetch); end
    next_cycle(); if_req = 1'b0;
    @(negedge clk);
    n_vec++; if ({mem_en, mem_we} !== 2'b10 || mem_addr !== 10'h005) begin n_err++; $display("FAIL t1_cmd: got en/we %b addr %h expected 10 005", {mem_en, mem_we}, mem_addr); end
    next_cycle(); @(negedge clk);
    n_vec++; if ({mem_en, if_rvalid, busy} !== 3'b001) begin n_err++; $display("FAIL t1_wait: got en/rv/busy %b expected 001", {mem_en, if_rvalid, busy}); end
    next_cycle(); @(negedge clk);
    n_vec++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL t1_rvalid: got %b %h expected 1 deadbeef", if_rvalid, if_rdata); end
    next_cycle(); @(negedge clk);
    n_vec++; if (if_rvalid !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL t1_hold: got %b %h expected 0 deadbeef", if_rvalid, if_rdata); end
  endtask

  task automatic test_store();
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h010; d_wdata = 32'h12345678;
    @(negedge clk);
    n_vec++; if (d_gnt !== 1'b1 || mem_en !== 1'b0) begin n_err++; $display("FAIL t2_gnt: got gnt %b en %b expected 1 0", d_gnt, mem_en); end
    next_cycle(); d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    @(negedge clk);
    n_vec++; if ({mem_en, mem_we} !== 2'b11 || mem_wdata !== 32'h12345678 || mem_addr !== 10'h010) begin n_err++; $display("FAIL t2_cmd: got %b %h %h expected 11 12345678 010", {mem_en, mem_we}, mem_wdata, mem_addr); end
    next_cycle(); @(negedge clk);
    n_vec++; if ({mem_en, mem_we, d_done} !== 3'b000 || mem_wdata !== 32'h12345678) begin n_err++; $display("FAIL t2_wait: got %b %h expected 000 12345678", {mem_en, mem_we, d_done}, mem_wdata); end
    next_cycle(); @(negedge clk);
    n_vec++; if (d_done !== 1'b1 || d_rdata !== 32'h0) begin n_err++; $display("FAIL t2_done: got %b %h expected 1 00000000", d_done, d_rdata); end
  endtask

  task automatic test_collision();
    next_cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010; if_req = 1'b1; if_addr = 10'h005;
    @(negedge clk);
    n_vec++; if ({d_gnt, if_gnt, stall_fetch} !== 3'b101) begin n_err++; $display("FAIL t3_arb: got d/if/stall %b expected 101", {d_gnt, if_gnt, stall_fetch}); end
    next_cycle(); d_req = 1'b0;
    @(negedge clk);
    n_vec++; if (stall_fetch !== 1'b1 || mem_addr !== 10'h010) begin n_err++; $display("FAIL t3_cmd: got stall %b addr %h expected 1 010", stall_fetch, mem_addr); end
    next_cycle(); @(negedge clk);
    n_vec++; if (stall_fetch !== 1'b1 || if_gnt !== 1'b0) begin n_err++; $display("FAIL t3_wait: got stall %b gnt %b expected 1 0", stall_fetch, if_gnt); end
    next_cycle(); @(negedge clk);
    n_vec++; if ({d_done, if_gnt, stall_fetch} !== 3'b110 || d_rdata !== 32'h12345678) begin n_err++; $display("FAIL t3_handoff: got %b %h expected 110 12345678", {d_done, if_gnt, stall_fetch}, d_rdata); end
    next_cycle(); if_req = 1'b0;
    @(negedge clk);
    n_vec++; if (mem_en !== 1'b1 || mem_addr !== 10'h005) begin n_err++; $display("FAIL t3_if_cmd: got %b %h expected 1 005", mem_en, mem_addr); end
    next_cycle(); next_cycle(); @(negedge clk);
    n_vec++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL t3_if_rvalid: got %b %h expected 1 deadbeef", if_rvalid, if_rdata); end
  endtask

  task automatic test_long_latency();
    next_cycle();
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 10'h3FF;
    @(negedge clk);
    n_vec++; if (b_d_gnt !== 1'b1 || b_busy !== 1'b0) begin n_err++; $display("FAIL t4_gnt: got %b busy %b expected 1 0", b_d_gnt, b_busy); end
    next_cycle(); b_d_req = 1'b0;
    @(negedge clk);
    n_vec++; if ({b_mem_en, b_mem_we, b_busy} !== 3'b101 || b_mem_addr !== 10'h3FF || b_mem_wdata !== 32'h0) begin n_err++; $display("FAIL t4_cmd: got %b %h %h expected 101 3ff 0", {b_mem_en, b_mem_we, b_busy}, b_mem_addr, b_mem_wdata); end
    for (int c = 2; c <= 4; c++) begin
      next_cycle(); @(negedge clk);
      n_vec++; if ({b_busy, b_d_done, b_mem_en} !== 3'b100) begin n_err++; $display("FAIL t4_wait%0d: got busy/done/en %b expected 100", c, {b_busy, b_d_done, b_mem_en}); end
    end
    next_cycle(); @(negedge clk);
    n_vec++; if ({b_d_done, b_busy} !== 2'b10 || b_d_rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL t4_done: got %b %h expected 10 cafef00d", {b_d_done, b_busy}, b_d_rdata); end
  endtask

  task automatic test_reset_mid_access();
    bit seen_done;
    next_cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
    @(negedge clk);
    n_vec++; if (d_gnt !== 1'b1) begin n_err++; $display("FAIL t5_gnt: got %b expected 1", d_gnt); end
    next_cycle(); d_req = 1'b0;
    next_cycle();
    rst = 1'b1; #1;
    n_vec++; if ({busy, mem_en, d_done, if_rvalid} !== 4'b0 || {d_rdata, if_rdata} !== 64'h0 || mem_addr !== 10'h0) begin n_err++; $display("FAIL t5_async: got %b %h %h %h expected zeros", {busy, mem_en, d_done, if_rvalid}, d_rdata, if_rdata, mem_addr); end
    next_cycle(); rst = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); if (d_done || if_rvalid || busy) seen_done = 1'b1;
      next_cycle();
    end
    n_vec++; if (seen_done !== 1'b0) begin n_err++; $display("FAIL t5_no_done: got activity %b expected 0", seen_done); end
    if_req = 1'b1; if_addr = 10'h005;
    @(negedge clk);
    n_vec++; if (if_gnt !== 1'b1) begin n_err++; $display("FAIL t5_regnt: got %b expected 1", if_gnt); end
    next_cycle(); if_req = 1'b0;
    next_cycle(); next_cycle(); @(negedge clk);
    n_vec++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL t5_resume: got %b %h expected 1 deadbeef", if_rvalid, if_rdata); end
  endtask

  task automatic test_starvation();
    int seq[$];
    int exp_seq[6];
`ifdef MEM_ARB_ANTISTARVE_EN
    exp_seq = '{1, 1, 1, 1, 2, 1};
`else
    exp_seq = '{1, 1, 1, 1, 1, 1};
`endif
    next_cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020; if_req = 1'b1; if_addr = 10'h005;
    for (int c = 0; c < 40 && seq.size() < 6; c++) begin
      @(negedge clk);
      if (d_gnt) seq.push_back(1);
      if (if_gnt) seq.push_back(2);
      next_cycle();
    end
    d_req = 1'b0; if_req = 1'b0;
    n_vec++; if (seq.size() != 6) begin n_err++; $display("FAIL t6_count: got %0d grants expected 6", seq.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < seq.size()) begin
        n_vec++; if (seq[i] != exp_seq[i]) begin n_err++; $display("FAIL t6_grant%0d: got %0d expected %0d (1=data 2=fetch)", i, seq[i], exp_seq[i]); end
      end
    end
    repeat (6) next_cycle();
  endtask

  initial begin
    test_reset();
    test_store();
    test_collision();
    test_long_latency();
    test_reset_mid_access();
    test_starvation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
